// File: rtl/connect_four_drop_engine_pkg.sv
// connect_four_pkg: shared constants, cell encoding and cell-to-pixel mapping
// for the Connect Four drop engine.
//   NUM_COLS / NUM_ROWS : board geometry (8 columns, 6 rows per column)
//   COL_NONE            : decoded column value meaning "no valid request"
//   cell_t              : per-cell board state
//   pix_row / pix_col   : cell coordinates -> bottom-left pixel of the 2x2 block
package connect_four_pkg;

  localparam int NUM_COLS = 8;
  localparam int NUM_ROWS = 6;

  localparam logic [3:0] COL_NONE  = 4'd8;
  localparam logic [2:0] ROW_LIMIT = 3'(NUM_ROWS);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RED   = 2'd1,
    GRN   = 2'd2
  } cell_t;

  // Row 0 of the board sits at the bottom of the display (pixel row 15).
  function automatic logic [4:0] pix_row(input logic [2:0] r);
    return 5'd15 - {1'b0, r, 1'b0};
  endfunction

  function automatic logic [4:0] pix_col(input logic [2:0] c);
    return {1'b0, c, 1'b0};
  endfunction

endpackage

// File: rtl/connect_four_drop_engine_if.sv
// connect_four_drop_engine_if: groups the drop request and the game-state
// outputs of the drop engine.
//   sw_sync    : one-hot drop request (master -> slave)
//   column     : decoded column, COL_NONE when no valid request
//   player     : player to move (0 = red, 1 = green)
//   counters   : tokens per column
//   red_pixels / grn_pixels : LED arrays [pixel_row][pixel_col], row 15 bottom
//   prev_row / prev_col     : pixel coordinates of the last placed token
interface connect_four_drop_engine_if;
  import connect_four_pkg::*;

  logic [NUM_COLS-1:0]       sw_sync;
  logic [3:0]                column;
  logic                      player;
  logic [NUM_COLS-1:0][2:0]  counters;
  logic [15:0][15:0]         red_pixels;
  logic [15:0][15:0]         grn_pixels;
  logic [4:0]                prev_row;
  logic [4:0]                prev_col;

  modport master (
    output sw_sync,
    input  column, player, counters, red_pixels, grn_pixels, prev_row, prev_col
  );

  modport slave (
    input  sw_sync,
    output column, player, counters, red_pixels, grn_pixels, prev_row, prev_col
  );
endinterface

// File: rtl/connect_four_drop_engine_decoder.sv
// drop_column_decoder: one-hot drop request to column index.
//   reset_i   : synchronous reset of the engine; forces "no request"
//   sw_sync_i : edge-detected one-hot request
//   column_o  : index of the single set bit, COL_NONE otherwise
module drop_column_decoder
  import connect_four_pkg::*;
(
  input  logic                reset_i,
  input  logic [NUM_COLS-1:0] sw_sync_i,
  output logic [3:0]          column_o
);

  always_comb begin
    column_o = COL_NONE;
    if (!reset_i && $onehot(sw_sync_i)) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (sw_sync_i[c]) column_o = 4'(c);
      end
    end
  end

endmodule

// File: rtl/connect_four_drop_engine.sv
// connect_four_drop_engine: Connect Four game-state core. Accepts one-hot drop
// requests, stacks tokens per column, alternates players and drives the red
// and green 16x16 LED arrays.
//   clk   : system clock
//   reset : synchronous, active-high; clears the board in one cycle
//   bus   : slave side of connect_four_drop_engine_if (request in, state out)
module connect_four_drop_engine
  import connect_four_pkg::*;
(
  input logic                     clk,
  input logic                     reset,
  connect_four_drop_engine_if.slave bus
);

  logic [3:0]               column;
  logic [2:0]               col_sel;
  logic [2:0]               row_sel;
  logic                     accept;

  logic [NUM_COLS-1:0][2:0] counters_q;
  logic                     player_q;
  logic [4:0]               prev_row_q;
  logic [4:0]               prev_col_q;
  cell_t                    board_q [NUM_ROWS][NUM_COLS];

  logic [15:0][15:0]        red_d;
  logic [15:0][15:0]        grn_d;

  drop_column_decoder u_decoder (
    .reset_i   (reset),
    .sw_sync_i (bus.sw_sync),
    .column_o  (column)
  );

  assign col_sel = column[2:0];
  assign row_sel = counters_q[col_sel];
  assign accept  = (column < COL_NONE) && (row_sel < ROW_LIMIT) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      counters_q <= '0;
      player_q   <= 1'b0;
      prev_row_q <= '0;
      prev_col_q <= '0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          board_q[r][c] <= EMPTY;
        end
      end
    end else if (accept) begin
      board_q[row_sel][col_sel] <= player_q ? GRN : RED;
      counters_q[col_sel]       <= row_sel + 3'd1;
      player_q                  <= ~player_q;
      prev_row_q                <= pix_row(row_sel);
      prev_col_q                <= pix_col(col_sel);
    end
  end

  // Each cell lights a 2x2 block; pixel rows 0..3 are never covered.
  always_comb begin
    red_d = '0;
    grn_d = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (board_q[r][c] == RED) begin
          red_d[15-2*r][2*c]   = 1'b1;
          red_d[15-2*r][2*c+1] = 1'b1;
          red_d[14-2*r][2*c]   = 1'b1;
          red_d[14-2*r][2*c+1] = 1'b1;
        end else if (board_q[r][c] == GRN) begin
          grn_d[15-2*r][2*c]   = 1'b1;
          grn_d[15-2*r][2*c+1] = 1'b1;
          grn_d[14-2*r][2*c]   = 1'b1;
          grn_d[14-2*r][2*c+1] = 1'b1;
        end
      end
    end
  end

  assign bus.column     = column;
  assign bus.player     = player_q;
  assign bus.counters   = counters_q;
  assign bus.red_pixels = red_d;
  assign bus.grn_pixels = grn_d;
  assign bus.prev_row   = prev_row_q;
  assign bus.prev_col   = prev_col_q;

endmodule

// File: tb/tb_connect_four_drop_engine.sv
// Directed self-checking bench for connect_four_drop_engine.
module tb_connect_four_drop_engine;
  import connect_four_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [15:0][15:0] exp_red;
  logic [15:0][15:0] exp_grn;
  logic [7:0][2:0]   exp_cnt;

  connect_four_drop_engine_if cf_if ();

  connect_four_drop_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_cell(input int c, input int r, input bit grn);
    if (grn) begin
      exp_grn[15-2*r][2*c] = 1'b1; exp_grn[15-2*r][2*c+1] = 1'b1;
      exp_grn[14-2*r][2*c] = 1'b1; exp_grn[14-2*r][2*c+1] = 1'b1;
    end else begin
      exp_red[15-2*r][2*c] = 1'b1; exp_red[15-2*r][2*c+1] = 1'b1;
      exp_red[14-2*r][2*c] = 1'b1; exp_red[14-2*r][2*c+1] = 1'b1;
    end
  endtask

  task automatic exp_clear();
    exp_red = '0;
    exp_grn = '0;
    exp_cnt = '0;
  endtask

  task automatic pulse(input logic [7:0] v);
    @(negedge clk) cf_if.sw_sync = v;
    @(negedge clk) cf_if.sw_sync = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic check_board(input string tag, input logic exp_player);
    chk({tag, " counters"}, cf_if.counters, exp_cnt);
    chk({tag, " red"}, cf_if.red_pixels, exp_red);
    chk({tag, " grn"}, cf_if.grn_pixels, exp_grn);
    chk({tag, " player"}, cf_if.player, exp_player);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    cf_if.sw_sync = 8'h00;
    exp_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset, idle
    check_board("reset", 1'b0);
    chk("reset column", cf_if.column, 4'd8);
    chk("reset prev_row", cf_if.prev_row, 5'd0);
    chk("reset prev_col", cf_if.prev_col, 5'd0);

    // Single drops in column 0
    @(negedge clk) cf_if.sw_sync = 8'h01;
    #1 chk("decode col0", cf_if.column, 4'd0);
    @(negedge clk) cf_if.sw_sync = 8'h00;
    exp_cell(0, 0, 1'b0); exp_cnt[0] = 3'd1;
    check_board("drop1", 1'b1);
    chk("drop1 prev_row", cf_if.prev_row, 5'd15);
    chk("drop1 prev_col", cf_if.prev_col, 5'd0);
    chk("drop1 red[15][0]", cf_if.red_pixels[15][0], 1'b1);
    chk("drop1 red[14][1]", cf_if.red_pixels[14][1], 1'b1);
    pulse(8'h01);
    exp_cell(0, 1, 1'b1); exp_cnt[0] = 3'd2;
    check_board("drop2", 1'b0);
    chk("drop2 prev_row", cf_if.prev_row, 5'd13);
    chk("drop2 grn[12][1]", cf_if.grn_pixels[12][1], 1'b1);

    // One-cycle sweep across all columns
    do_reset();
    exp_clear();
    check_board("sweep reset", 1'b0);
    for (int c = 0; c < 8; c++) begin
      pulse(8'h01 << c);
      exp_cell(c, 0, c[0]); exp_cnt[c] = 3'd1;
      chk("sweep prev_col", cf_if.prev_col, 5'(2*c));
      chk("sweep prev_row", cf_if.prev_row, 5'd15);
    end
    check_board("sweep end", 1'b0);
    chk("sweep counters", cf_if.counters, 24'h249249);

    // Fill column 3, then overflow attempt
    do_reset();
    exp_clear();
    for (int r = 0; r < 6; r++) begin
      pulse(8'h08);
      exp_cell(3, r, r[0]);
    end
    exp_cnt[3] = 3'd6;
    check_board("col3 full", 1'b0);
    chk("col3 full prev_row", cf_if.prev_row, 5'd5);
    chk("col3 full prev_col", cf_if.prev_col, 5'd6);
    @(negedge clk) cf_if.sw_sync = 8'h08;
    #1 chk("col3 7th decode", cf_if.column, 4'd3);
    @(negedge clk) cf_if.sw_sync = 8'h00;
    check_board("col3 7th", 1'b0);
    chk("col3 7th prev_row", cf_if.prev_row, 5'd5);

    // Multi-hot request
    @(negedge clk) cf_if.sw_sync = 8'h03;
    #1 chk("multihot decode", cf_if.column, 4'd8);
    @(negedge clk) cf_if.sw_sync = 8'h00;
    check_board("multihot", 1'b0);

    // Mid-game reset
    pulse(8'h01);
    pulse(8'h02);
    chk("premid player", cf_if.player, 1'b0);
    do_reset();
    exp_clear();
    check_board("midreset", 1'b0);
    chk("midreset prev_row", cf_if.prev_row, 5'd0);
    chk("midreset prev_col", cf_if.prev_col, 5'd0);

    // Reset and request in the same cycle
    @(negedge clk) begin reset = 1'b1; cf_if.sw_sync = 8'h10; end
    #1 chk("reset+req decode", cf_if.column, 4'd8);
    @(negedge clk) begin reset = 1'b0; cf_if.sw_sync = 8'h00; end
    check_board("reset+req", 1'b0);

    // Held request for three cycles
    @(negedge clk) cf_if.sw_sync = 8'h04;
    repeat (3) @(negedge clk);
    cf_if.sw_sync = 8'h00;
    exp_cell(2, 0, 1'b0); exp_cell(2, 1, 1'b1); exp_cell(2, 2, 1'b0);
    exp_cnt[2] = 3'd3;
    check_board("held", 1'b1);
    chk("held prev_row", cf_if.prev_row, 5'd11);
    chk("held prev_col", cf_if.prev_col, 5'd4);
    chk("held rows0-3 red", cf_if.red_pixels[3:0], 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/connect_four_drop_engine.md
Name: connect_four_drop_engine

Overview:
- Game-state core of the 8-column Connect Four design: decodes a one-hot drop request into a column, tracks whose turn it is, keeps per-column fill counters and drives the 16x16 red/green LED pixel arrays.
- Input is the edge-detected switch vector from the synchronizer.
- Outputs feed the player 7-seg display and the win checker (last-placed token coordinates).

Parameters:
- NUM_COLS, 8, board columns; only 8 is supported, since it is tied to the sw_sync width.
- NUM_ROWS, 6, board rows per column; the counter width of 3 bits requires NUM_ROWS <= 7.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sw_sync  in  8  edge-detected one-hot drop request; bit c = drop in column c
- column  out  4  decoded column 0..7; 4'd8 = no request
- player  out  1  player to move: 0 = player 1 (red), 1 = player 2 (green)
- counters  out  [7:0][2:0]  tokens currently in each column, 0..NUM_ROWS
- red_pixels  out  [15:0][15:0]  red LED array, indexed [pixel_row][pixel_col]; row 15 = bottom
- grn_pixels  out  [15:0][15:0]  green LED array, same indexing
- prev_row  out  5  pixel row of last placed token (bottom pixel of its cell)
- prev_col  out  5  pixel column of last placed token (left pixel of its cell)

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - Reset is synchronous and active-high, and dominates all other inputs.
- Column decode (combinational):
  - column = index of the set bit when sw_sync has exactly one bit set.
  - Otherwise column = 4'd8: zero bits set, two or more bits set, or reset asserted.
- Drop acceptance (combinational):
  - accept = (column < 8) && (counters[column] < NUM_ROWS) && !reset.
- Accepted drop, all updates at the next clk edge:
  - Cell (c = column, r = counters[c]) is lit in the current player's colour.
  - counters[c] increments by 1.
  - player toggles.
  - prev_row = 15 - 2r; prev_col = 2c.
- Cell-to-pixel mapping:
  - Each cell is a 2x2 block: pixel rows 15-2r and 14-2r, pixel cols 2c and 2c+1.
  - Red cells set red_pixels bits only; green cells set grn_pixels bits only.
  - A pixel is never set in both arrays.
  - Pixel rows 0..3 are always 0.
- Rejected request (full column, invalid or multi-hot):
  - No state change; player does not toggle.
- Held requests:
  - Every cycle with an accepted request places a token.
  - Single drops therefore rely on sw_sync being a one-cycle pulse.
- Reset values:
  - All counters 0; both pixel arrays all-zero; player 0; prev_row 0; prev_col 0.
  - Reset mid-game clears the board in one cycle.
- Latency:
  - Pixels, counters, player and prev_* update 1 cycle after the request; column is combinational.
- Storage:
  - Board state is one 2-bit cell code per cell (EMPTY/RED/GRN); pixel arrays are decoded from it.
  - Alternatively the pixel arrays are registered directly; both implementations are allowed if the outputs match.
- The block does no win detection. It keeps accepting drops after a win until reset.

Decomposition:
- Shared package connect_four_pkg:
  - NUM_COLS, NUM_ROWS, COL_NONE = 4'd8.
  - cell_t enum {EMPTY, RED, GRN}.
  - Pixel mapping helper functions (cell row/col -> pixel row/col).
- One natural sub-module: drop_column_decoder (one-hot to column with COL_NONE).
- Player register, counters and board are kept in the top.

Test Plan:
- Reset, then idle:
  - counters all 0, both arrays 0, player=0, column=8.
- Single drops:
  - Pulse sw_sync=8'h01 one cycle: red_pixels[15][0], [15][1], [14][0], [14][1] = 1; counters[0]=1; player=1; prev_row=15, prev_col=0.
  - Then pulse 8'h01 again: grn_pixels rows 13/12, cols 0/1 set; counters[0]=2; player=0; prev_row=13.
- One-cycle sweep:
  - Pulse 8'h01, 8'h02, ... 8'h80 one cycle each: columns 0..7 each get one token, alternating red/green starting red; counters all 1; player=0 at the end.
- Full column and invalid requests:
  - Fill column 3 with 6 drops, then a 7th: counters[3] stays 6, player unchanged, arrays unchanged.
  - sw_sync=8'h03: column=8, no change.
- Mid-game reset:
  - After several drops, assert reset one cycle: all outputs return to reset values.
  - With reset and sw_sync=8'h10 in the same cycle, reset wins and the board stays empty.
- Held request:
  - sw_sync=8'h04 held 3 cycles: counters[2]=3, tokens red/green/red, player=1.
